commit_trace_monitor: RTL and testbench

//  Synthesizable successor to the per-cycle register dump used in simulation.

---
 rtl/commit_trace_monitor_pkg.sv | 25 ++
 rtl/commit_trace_monitor_if.sv | 33 +++
 rtl/commit_trace_monitor_sync_fifo.sv | 87 ++++++++
 rtl/commit_trace_monitor.sv | 149 ++++++++++++++
 tb/tb_commit_trace_monitor.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/commit_trace_monitor_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : commit_trace_monitor_pkg
//  Description : Shared definitions for the commit trace monitor: default
//                register watch mask, halt FSM state encoding and the trace
//                record width. Record layout, MSB to LSB:
//                {cycle[CYC_W], pc[XLEN], wen[1], waddr[RA_W], wdata[XLEN]}
//  Revision    : 1.0 - initial release
// ============================================================================
package commit_trace_monitor_pkg;

    // $t0-$t9 and $s0-$s7 (registers 8..25)
    localparam logic [31:0] c_DEFAULT_WATCH_MASK = 32'h03FF_FF00;

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } halt_state_t;

    function automatic int rec_width(input int xlen, input int ra_w, input int cyc_w);
        return cyc_w + xlen + 1 + ra_w + xlen;
    endfunction

endpackage
`default_nettype wire

// File: rtl/commit_trace_monitor_if.sv
`default_nettype none
// ============================================================================
//  Module      : commit_trace_monitor_if
//  Description : Trace record drain handshake (valid/ready) plus the record
//                fields presented with it.
//                master : monitor side, drives valid and record fields
//                slave  : consumer side, drives ready
//  Revision    : 1.0 - initial release
// ============================================================================
interface commit_trace_monitor_if #(
    parameter int XLEN  = 32,
    parameter int RA_W  = 5,
    parameter int CYC_W = 16
);
    logic             tr_valid;
    logic             tr_ready;
    logic [CYC_W-1:0] tr_cycle;
    logic [XLEN-1:0]  tr_pc;
    logic             tr_wen;
    logic [RA_W-1:0]  tr_waddr;
    logic [XLEN-1:0]  tr_wdata;

    modport master (
        output tr_valid, tr_cycle, tr_pc, tr_wen, tr_waddr, tr_wdata,
        input  tr_ready
    );

    modport slave (
        input  tr_valid, tr_cycle, tr_pc, tr_wen, tr_waddr, tr_wdata,
        output tr_ready
    );
endinterface
`default_nettype wire

// File: rtl/commit_trace_monitor_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : commit_trace_monitor_sync_fifo
//  Description : Single-clock show-ahead FIFO with a registered head output.
//                dout always holds the current head; when the FIFO empties it
//                keeps the last popped word. A push while full is accepted only
//                if a pop happens in the same cycle.
//  Ports       : clk, rst_n (async active-low), push, pop, din,
//                full, empty, dout
//  Revision    : 1.0 - initial release
// ============================================================================
module commit_trace_monitor_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             push,
    input  wire logic             pop,
    input  wire logic [WIDTH-1:0] din,
    output logic                  full,
    output logic                  empty,
    output logic      [WIDTH-1:0] dout
);
    localparam int               c_AW    = $clog2(DEPTH);
    localparam logic [c_AW:0]    c_FULL  = (c_AW+1)'(DEPTH);
    localparam logic [c_AW:0]    c_CNT1  = (c_AW+1)'(1);
    localparam logic [c_AW-1:0]  c_PTR1  = c_AW'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;
    logic [WIDTH-1:0] r_dout;

    logic             w_do_pop;
    logic             w_do_push;
    logic [c_AW-1:0]  w_rd_ptr_inc;

    assign full         = (r_count == c_FULL);
    assign empty        = (r_count == '0);
    assign dout         = r_dout;
    assign w_do_pop     = pop & ~empty;
    // A full FIFO frees the head slot when it pops, so the push can land there.
    assign w_do_push    = push & (~full | w_do_pop);
    assign w_rd_ptr_inc = r_rd_ptr + c_PTR1;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_dout   <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= w_rd_ptr_inc;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_CNT1;
                2'b01:   r_count <= r_count - c_CNT1;
                default: r_count <= r_count;
            endcase
            // Head register: after a pop the next entry is either already
            // stored or is the word arriving this very cycle; if nothing
            // follows, the last popped word is kept.
            if (w_do_pop) begin
                if (r_count > c_CNT1) begin
                    r_dout <= r_mem[w_rd_ptr_inc];
                end else if (w_do_push) begin
                    r_dout <= din;
                end
            end else if (empty && w_do_push) begin
                r_dout <= din;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/commit_trace_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : commit_trace_monitor
//  Description : Taps the commit/writeback port and records qualifying commits
//                as {cycle, pc, wen, reg, data} records into a trace FIFO that
//                is drained through a valid/ready interface. Provides register
//                watch masking, full-commit mode, overflow accounting and halt
//                detection (repeated PC or explicit halt PC).
//  Ports       : clk, rst_n (async active-low)
//                mode, halt_pc, halt_pc_en        - configuration
//                cm_valid/pc/wen/waddr/wdata      - commit port tap
//                tr (master)                      - trace record drain
//                overflow, drop_cnt, halted       - status
//  Revision    : 1.0 - initial release
// ============================================================================
module commit_trace_monitor
    import commit_trace_monitor_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter int              NREG        = 32,
    parameter int              DEPTH       = 16,
    parameter int              CYC_W       = 16,
    parameter logic [NREG-1:0] WATCH_MASK  = c_DEFAULT_WATCH_MASK,
    parameter int              STALL_LIMIT = 4,
    localparam int             RA_W        = $clog2(NREG)
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    input  wire logic            mode,
    input  wire logic [XLEN-1:0] halt_pc,
    input  wire logic            halt_pc_en,
    input  wire logic            cm_valid,
    input  wire logic [XLEN-1:0] cm_pc,
    input  wire logic            cm_wen,
    input  wire logic [RA_W-1:0] cm_waddr,
    input  wire logic [XLEN-1:0] cm_wdata,
    commit_trace_monitor_if.master tr,
    output logic                 overflow,
    output logic           [7:0] drop_cnt,
    output logic                 halted
);
    localparam int                c_REC_W = rec_width(XLEN, RA_W, CYC_W);
    // Stall counter holds 0..STALL_LIMIT+1 so it never wraps back onto the limit
    localparam int                c_SC_W  = $clog2(STALL_LIMIT + 2);
    localparam logic [c_SC_W-1:0] c_LIMIT = c_SC_W'(STALL_LIMIT);
    localparam logic [c_SC_W-1:0] c_SC1   = c_SC_W'(1);
    localparam logic [CYC_W-1:0]  c_CYC1  = CYC_W'(1);

    halt_state_t        r_state;
    halt_state_t        w_state_next;
    logic [CYC_W-1:0]   r_cycle;
    logic [XLEN-1:0]    r_prev_pc;
    logic [c_SC_W-1:0]  r_stall;
    logic               r_overflow;
    logic [7:0]         r_drop_cnt;

    logic               w_halted;
    logic               w_qualify;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic               w_drop;
    logic               w_same_pc;
    logic [c_SC_W-1:0]  w_stall_next;
    logic               w_halt_hit;
    logic [c_REC_W-1:0] w_din;
    logic [c_REC_W-1:0] w_dout;

    assign w_halted  = (r_state == ST_HALTED);
    // Register 0 is hard-wired, so its writes are never worth logging.
    assign w_qualify = cm_valid & ~w_halted &
                       (mode | (cm_wen & WATCH_MASK[cm_waddr] & (cm_waddr != '0)));
    assign w_pop     = tr.tr_valid & tr.tr_ready;
    assign w_drop    = w_qualify & w_full & ~w_pop;
    assign w_din     = {r_cycle, cm_pc, cm_wen, cm_waddr, cm_wdata};

    commit_trace_monitor_sync_fifo #(
        .WIDTH (c_REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_qualify),
        .pop   (tr.tr_ready),
        .din   (w_din),
        .full  (w_full),
        .empty (w_empty),
        .dout  (w_dout)
    );

    assign tr.tr_valid = ~w_empty;
    assign {tr.tr_cycle, tr.tr_pc, tr.tr_wen, tr.tr_waddr, tr.tr_wdata} = w_dout;

    assign overflow = r_overflow;
    assign drop_cnt = r_drop_cnt;
    assign halted   = w_halted;

    // Stall tracking: reset value 0 makes the first commit land on 1
    // whether or not its PC equals the reset value of r_prev_pc.
    assign w_same_pc    = (cm_pc == r_prev_pc);
    assign w_stall_next = !w_same_pc     ? c_SC1 :
                          (r_stall == '1) ? r_stall : r_stall + c_SC1;
    assign w_halt_hit   = ((STALL_LIMIT != 0) && (w_stall_next == c_LIMIT)) ||
                          (halt_pc_en && (cm_pc == halt_pc));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RUN: begin
                if (cm_valid && w_halt_hit) begin
                    w_state_next = ST_HALTED;
                end
            end
            ST_HALTED: w_state_next = ST_HALTED;
            default:   w_state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycle    <= '0;
            r_prev_pc  <= '0;
            r_stall    <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            r_cycle <= r_cycle + c_CYC1;
            if (cm_valid && !w_halted) begin
                r_prev_pc <= cm_pc;
                r_stall   <= w_stall_next;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != 8'hFF) begin
                    r_drop_cnt <= r_drop_cnt + 8'd1;
                end
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_commit_trace_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_commit_trace_monitor
//  Description : Self-checking bench for commit_trace_monitor. A queue-based
//                model of the trace buffer, cycle stamp and halt rules is
//                compared against the DUT every cycle; directed sequences pin
//                the model with literal expectations, then randomized traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_commit_trace_monitor;
    import commit_trace_monitor_pkg::*;

    localparam int XLEN        = 32;
    localparam int NREG        = 32;
    localparam int RA_W        = 5;
    localparam int DEPTH       = 8;
    localparam int CYC_W       = 4;
    localparam int STALL_LIMIT = 4;

    typedef struct {
        logic [CYC_W-1:0] cyc;
        logic [XLEN-1:0]  pc;
        logic             wen;
        logic [RA_W-1:0]  waddr;
        logic [XLEN-1:0]  wdata;
    } rec_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            mode = 1'b0;
    logic [XLEN-1:0] halt_pc = '0;
    logic            halt_pc_en = 1'b0;
    logic            cm_valid = 1'b0;
    logic [XLEN-1:0] cm_pc = '0;
    logic            cm_wen = 1'b0;
    logic [RA_W-1:0] cm_waddr = '0;
    logic [XLEN-1:0] cm_wdata = '0;
    logic            overflow;
    logic [7:0]      drop_cnt;
    logic            halted;
    logic [31:0]     watch = 32'h03FF_FF00;

    int n_cmp = 0;
    int n_bad = 0;

    // model state
    rec_t mq[$];
    rec_t m_last;
    int   m_cycle;
    bit   m_halted;
    bit   m_over;
    int   m_drop;
    int   m_stall;
    logic [XLEN-1:0] m_prev_pc;

    // accepted-record log built from DUT outputs
    rec_t acc[$];
    rec_t s_rec;
    bit   s_valid = 1'b0;
    rec_t e_rec;

    commit_trace_monitor_if #(.XLEN(XLEN), .RA_W(RA_W), .CYC_W(CYC_W)) tr_if ();

    commit_trace_monitor #(
        .XLEN        (XLEN),
        .NREG        (NREG),
        .DEPTH       (DEPTH),
        .CYC_W       (CYC_W),
        .WATCH_MASK  (32'h03FF_FF00),
        .STALL_LIMIT (STALL_LIMIT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mode       (mode),
        .halt_pc    (halt_pc),
        .halt_pc_en (halt_pc_en),
        .cm_valid   (cm_valid),
        .cm_pc      (cm_pc),
        .cm_wen     (cm_wen),
        .cm_waddr   (cm_waddr),
        .cm_wdata   (cm_wdata),
        .tr         (tr_if),
        .overflow   (overflow),
        .drop_cnt   (drop_cnt),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_last    = '{default: '0};
        m_cycle   = 0;
        m_halted  = 1'b0;
        m_over    = 1'b0;
        m_drop    = 0;
        m_stall   = 0;
        m_prev_pc = '0;
    endtask

    task automatic model_step();
        rec_t r;
        bit   qual;
        r.cyc   = CYC_W'(m_cycle);
        m_cycle = m_cycle + 1;
        r.pc    = cm_pc;
        r.wen   = cm_wen;
        r.waddr = cm_waddr;
        r.wdata = cm_wdata;
        qual = cm_valid && !m_halted &&
               (mode || (cm_wen && cm_waddr != 0 && watch[cm_waddr]));
        if (mq.size() > 0 && tr_if.tr_ready) m_last = mq.pop_front();
        if (qual) begin
            if (mq.size() < DEPTH) mq.push_back(r);
            else begin
                m_over = 1'b1;
                if (m_drop < 255) m_drop++;
            end
        end
        if (cm_valid && !m_halted) begin
            m_stall   = (cm_pc == m_prev_pc) ? m_stall + 1 : 1;
            m_prev_pc = cm_pc;
            if ((STALL_LIMIT != 0 && m_stall == STALL_LIMIT) ||
                (halt_pc_en && cm_pc == halt_pc))
                m_halted = 1'b1;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step();
    end

    // per-cycle compare, 1 time unit after the active edge
    always begin
        @(posedge clk);
        #1;
        if (rst_n) begin
            if (s_valid && tr_if.tr_ready) acc.push_back(s_rec);
            e_rec = (mq.size() > 0) ? mq[0] : m_last;
            chk("tr_valid", 64'(tr_if.tr_valid), 64'(mq.size() > 0));
            chk("tr_cycle", 64'(tr_if.tr_cycle), 64'(e_rec.cyc));
            chk("tr_pc",    64'(tr_if.tr_pc),    64'(e_rec.pc));
            chk("tr_wen",   64'(tr_if.tr_wen),   64'(e_rec.wen));
            chk("tr_waddr", 64'(tr_if.tr_waddr), 64'(e_rec.waddr));
            chk("tr_wdata", 64'(tr_if.tr_wdata), 64'(e_rec.wdata));
            chk("overflow", 64'(overflow),       64'(m_over));
            chk("drop_cnt", 64'(drop_cnt),       64'(m_drop));
            chk("halted",   64'(halted),         64'(m_halted));
            s_valid     = tr_if.tr_valid;
            s_rec.cyc   = tr_if.tr_cycle;
            s_rec.pc    = tr_if.tr_pc;
            s_rec.wen   = tr_if.tr_wen;
            s_rec.waddr = tr_if.tr_waddr;
            s_rec.wdata = tr_if.tr_wdata;
        end else begin
            s_valid = 1'b0;
        end
    end

    task automatic drive(input logic v, input logic [XLEN-1:0] pc, input logic w,
                         input logic [RA_W-1:0] a, input logic [XLEN-1:0] d);
        cm_valid = v;
        cm_pc    = pc;
        cm_wen   = w;
        cm_waddr = a;
        cm_wdata = d;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, '0, 1'b0, '0, '0);
    endtask

    // Called at a negedge; asserts reset mid-cycle, checks outputs clear at
    // once, releases on the next negedge.
    task automatic do_reset();
        cm_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst tr_valid", 64'(tr_if.tr_valid), 64'd0);
        chk("rst tr_pc",    64'(tr_if.tr_pc),    64'd0);
        chk("rst tr_cycle", 64'(tr_if.tr_cycle), 64'd0);
        chk("rst overflow", 64'(overflow),       64'd0);
        chk("rst drop_cnt", 64'(drop_cnt),       64'd0);
        chk("rst halted",   64'(halted),         64'd0);
        acc.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tr_if.tr_ready = 1'b0;
        repeat (2) @(negedge clk);
        do_reset();

        // watched-register filtering and cycle stamps
        mode = 1'b0;
        tr_if.tr_ready = 1'b1;
        drive(1'b1, 32'h1000, 1'b1, 5'd8,  32'h5);
        drive(1'b1, 32'h1004, 1'b1, 5'd1,  32'h7);
        drive(1'b1, 32'h1008, 1'b1, 5'd16, 32'hA);
        idle(4);
        chk("t2 count",  64'(acc.size()), 64'd2);
        if (acc.size() == 2) begin
            chk("t2 r0 reg",  64'(acc[0].waddr), 64'd8);
            chk("t2 r0 data", 64'(acc[0].wdata), 64'h5);
            chk("t2 r0 cyc",  64'(acc[0].cyc),   64'd0);
            chk("t2 r1 reg",  64'(acc[1].waddr), 64'd16);
            chk("t2 r1 data", 64'(acc[1].wdata), 64'hA);
            chk("t2 r1 cyc",  64'(acc[1].cyc),   64'd2);
        end

        // overflow, then push+pop while full
        do_reset();
        mode = 1'b1;
        tr_if.tr_ready = 1'b0;
        for (int i = 0; i < DEPTH + 3; i++)
            drive(1'b1, 32'h100 + 32'(4 * i), 1'((i % 2) == 1), 5'd8, 32'(i));
        chk("t3 overflow", 64'(overflow), 64'd1);
        chk("t3 drop",     64'(drop_cnt), 64'd3);
        tr_if.tr_ready = 1'b1;
        drive(1'b1, 32'h200, 1'b1, 5'd9, 32'hBEEF);
        tr_if.tr_ready = 1'b0;
        chk("t3 drop kept", 64'(drop_cnt), 64'd3);
        idle(1);
        tr_if.tr_ready = 1'b1;
        idle(DEPTH + 4);
        chk("t3 count", 64'(acc.size()), 64'(DEPTH + 1));
        if (acc.size() == DEPTH + 1) begin
            chk("t3 first", 64'(acc[0].pc),     64'h100);
            chk("t3 last0", 64'(acc[DEPTH-1].pc), 64'(32'h100 + 32'(4 * (DEPTH - 1))));
            chk("t3 pushd", 64'(acc[DEPTH].pc), 64'h200);
        end

        // backpressure: ready toggles every cycle
        do_reset();
        mode = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tr_if.tr_ready = 1'((i % 2) == 1);
            drive(1'b1, 32'h300 + 32'(4 * i), 1'b1, 5'd10, 32'h50 + 32'(i));
        end
        for (int i = 0; i < 20; i++) begin
            tr_if.tr_ready = 1'((i % 2) == 0);
            idle(1);
        end
        chk("t4 count", 64'(acc.size()), 64'd8);
        for (int i = 0; i < 8 && i < acc.size(); i++)
            chk("t4 order", 64'(acc[i].wdata), 64'(32'h50 + 32'(i)));

        // halt by repeated PC
        do_reset();
        mode = 1'b0;
        tr_if.tr_ready = 1'b1;
        for (int k = 1; k <= 3; k++) drive(1'b1, 32'h40, 1'b1, 5'd9, 32'(k));
        chk("t5 not yet", 64'(halted), 64'd0);
        drive(1'b1, 32'h40, 1'b1, 5'd9, 32'd4);
        chk("t5 halted", 64'(halted), 64'd1);
        drive(1'b1, 32'h44, 1'b1, 5'd17, 32'h99);
        idle(3);
        chk("t5 logged", 64'(acc.size()), 64'd4);

        // halt by explicit PC
        do_reset();
        halt_pc    = 32'h1C;
        halt_pc_en = 1'b1;
        for (int i = 0; i < 3; i++) drive(1'b1, 32'h10 + 32'(4 * i), 1'b1, 5'd8, 32'(i));
        chk("t5 pc before", 64'(halted), 64'd0);
        drive(1'b1, 32'h1C, 1'b1, 5'd8, 32'h77);
        chk("t5 pc halt", 64'(halted), 64'd1);
        halt_pc_en = 1'b0;
        idle(3);

        // cycle stamp wrap
        do_reset();
        mode = 1'b1;
        tr_if.tr_ready = 1'b0;
        idle(17);
        drive(1'b1, 32'h500, 1'b0, 5'd0, 32'h0);
        chk("t6 valid", 64'(tr_if.tr_valid), 64'd1);
        chk("t6 wrap",  64'(tr_if.tr_cycle), 64'd1);

        // randomized traffic, each round starting with a reset over live state
        for (int r = 0; r < 4; r++) begin
            do_reset();
            halt_pc = 32'h608;
            for (int c = 0; c < 150; c++) begin
                if ($urandom_range(0, 19) == 0) mode = ~mode;
                tr_if.tr_ready = ($urandom_range(0, 2) != 0);
                halt_pc_en     = ($urandom_range(0, 39) == 0);
                drive(1'($urandom_range(0, 3) != 0),
                      32'h600 + 32'(4 * $urandom_range(0, 2)),
                      1'($urandom_range(0, 1)),
                      5'($urandom_range(0, 31)),
                      $urandom);
            end
        end
        halt_pc_en = 1'b0;
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
